// File: rtl/alu_4bit.sv
// Registered ALU: AND/OR/XOR/ADD with carry and zero flags.
// One output register stage, asynchronous active-high reset.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero_flag
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_carry;
  logic             nxt_zero;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    nxt_out   = '0;
    nxt_carry = 1'b0;
    case (sel)
      2'b00: nxt_out = a & b;
      2'b01: nxt_out = a | b;
      2'b10: nxt_out = a ^ b;
      2'b11: begin
        nxt_out   = sum[WIDTH-1:0];
        nxt_carry = sum[WIDTH];
      end
      // X/Z on sel falls here so it is never aliased to a real op
      default: begin
        nxt_out   = '0;
        nxt_carry = 1'b0;
      end
    endcase
  end

  // zero is derived from the next result so it tracks the registered out
  assign nxt_zero = (nxt_out == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b1;
    end else begin
      out       <= nxt_out;
      carry_out <= nxt_carry;
      zero_flag <= nxt_zero;
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed self-checking bench for alu_4bit.
// Each task drives vectors and compares {out,carry,zero} inline.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] sel;
  logic [3:0] out;
  logic       carry_out;
  logic       zero_flag;

  int tests;
  int fails;

  alu_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out       (out),
    .carry_out (carry_out),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive at negedge, sample 1ns after the following rising edge
  task automatic apply(input logic [3:0] va, input logic [3:0] vb,
                       input logic [1:0] vs);
    @(negedge clk);
    a   = va;
    b   = vb;
    sel = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b0000_0_1) begin
      fails++;
      $display("FAIL reset_init: got %b/%b/%b want 0000/0/1",
               out, carry_out, zero_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(4'b0111, 4'b0001, 2'b11);
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b1000_0_0) begin
      fails++;
      $display("FAIL reset_pre: got %b/%b/%b want 1000/0/0",
               out, carry_out, zero_flag);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b0000_0_1) begin
      fails++;
      $display("FAIL reset_async: got %b/%b/%b want 0000/0/1",
               out, carry_out, zero_flag);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b0000_0_1) begin
      fails++;
      $display("FAIL reset_held: got %b/%b/%b want 0000/0/1",
               out, carry_out, zero_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b1000_0_0) begin
      fails++;
      $display("FAIL reset_release: got %b/%b/%b want 1000/0/0",
               out, carry_out, zero_flag);
    end
  endtask

  task automatic test_add();
    logic [3:0] va [6] = '{4'b0000, 4'b0101, 4'b1111,
                           4'b1111, 4'b1000, 4'b0000};
    logic [3:0] vb [6] = '{4'b0000, 4'b0011, 4'b0001,
                           4'b1111, 4'b1000, 4'b1111};
    logic [5:0] ex [6] = '{6'b0000_0_1, 6'b1000_0_0, 6'b0000_1_1,
                           6'b1110_1_0, 6'b0000_1_1, 6'b1111_0_0};
    for (int i = 0; i < 6; i++) begin
      apply(va[i], vb[i], 2'b11);
      tests++;
      if ({out, carry_out, zero_flag} !== ex[i]) begin
        fails++;
        $display("FAIL add_%0d: %b+%b got %b/%b/%b want %b",
                 i, va[i], vb[i], out, carry_out, zero_flag, ex[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0] va [4] = '{4'b1010, 4'b1000, 4'b1100, 4'b1010};
    logic [3:0] vb [4] = '{4'b1100, 4'b0001, 4'b1010, 4'b1010};
    logic [1:0] vs [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [5:0] ex [4] = '{6'b1000_0_0, 6'b1001_0_0,
                           6'b0110_0_0, 6'b0000_0_1};
    for (int i = 0; i < 4; i++) begin
      apply(va[i], vb[i], vs[i]);
      tests++;
      if ({out, carry_out, zero_flag} !== ex[i]) begin
        fails++;
        $display("FAIL logic_%0d: sel=%b got %b/%b/%b want %b",
                 i, vs[i], out, carry_out, zero_flag, ex[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0] va [3] = '{4'b1010, 4'b0000, 4'b1010};
    logic [3:0] vb [3] = '{4'b0101, 4'b0000, 4'b1010};
    logic [1:0] vs [3] = '{2'b00, 2'b01, 2'b01};
    logic [5:0] ex [3] = '{6'b0000_0_1, 6'b0000_0_1, 6'b1010_0_0};
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], vs[i]);
      tests++;
      if ({out, carry_out, zero_flag} !== ex[i]) begin
        fails++;
        $display("FAIL zero_%0d: got %b/%b/%b want %b",
                 i, out, carry_out, zero_flag, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vs [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    logic [5:0] ex [4] = '{6'b1111_0_0, 6'b0000_0_1,
                           6'b1111_0_0, 6'b1111_0_0};
    for (int i = 0; i < 4; i++) begin
      apply(4'b1110, 4'b0001, vs[i]);
      tests++;
      if ({out, carry_out, zero_flag} !== ex[i]) begin
        fails++;
        $display("FAIL b2b_%0d: sel=%b got %b/%b/%b want %b",
                 i, vs[i], out, carry_out, zero_flag, ex[i]);
      end
    end
  endtask

  task automatic test_carry_clear();
    apply(4'b1111, 4'b0001, 2'b11);
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b0000_1_1) begin
      fails++;
      $display("FAIL carry_set: got %b/%b/%b want 0000/1/1",
               out, carry_out, zero_flag);
    end
    apply(4'b1111, 4'b1111, 2'b00);
    tests++;
    if ({out, carry_out, zero_flag} !== 6'b1111_0_0) begin
      fails++;
      $display("FAIL carry_clear: got %b/%b/%b want 1111/0/0",
               out, carry_out, zero_flag);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    a     = 4'b0;
    b     = 4'b0;
    sel   = 2'b00;
    #1;
    test_reset();
    test_add();
    test_logic();
    test_zero();
    test_back_to_back();
    test_carry_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
